// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and default sizing for the pipeline sequencing controller.
package pipeline_ctrl_pkg;

  localparam int unsigned DEF_JR_STALL_CYCLES = 3;
  localparam int unsigned DEF_DRAIN_CYCLES    = 3;
  localparam int unsigned DEF_CYC_W           = 32;

  typedef enum logic [2:0] {
    StIdle,
    StRun,
    StJrWait,
    StDrain,
    StHalted
  } state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tick_counter.sv
// Free-running wrapping counter of executed pipeline ticks.
module tick_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_q <= '0;
    end else if (i_en) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign o_count = count_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Turns hazard/HALT/debug requests into per-stage latch enables and an ID/EX bubble strobe.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned JR_STALL_CYCLES = DEF_JR_STALL_CYCLES,
  parameter int unsigned DRAIN_CYCLES    = DEF_DRAIN_CYCLES,
  parameter int unsigned CYC_W           = DEF_CYC_W
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load_stall,
  input  logic             i_jr_stall,
  input  logic             i_halt_ID,
  input  logic             i_dbg_run,
  input  logic             i_dbg_step,
  output logic             o_pc_en,
  output logic             o_if_id_en,
  output logic             o_id_ex_bubble,
  output logic             o_pipe_en,
  output logic             o_halted,
  output logic [CYC_W-1:0] o_cycle_cnt
);

  localparam int unsigned MAX_STALL = max_u(JR_STALL_CYCLES, DRAIN_CYCLES);
  localparam int unsigned CNT_W     = ($clog2(MAX_STALL) > 0) ? $clog2(MAX_STALL) : 1;
  localparam logic [CNT_W-1:0] JR_LOAD    = CNT_W'(JR_STALL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES - 1);

  state_e           state_q;
  logic             mode_q;     // 0: continuous, 1: single-step
  logic             jr_pass_q;
  logic [CNT_W-1:0] cnt_q;

  logic active;
  logic tick;
  logic front_freeze;

  always_comb begin
    active       = (state_q == StRun) || (state_q == StJrWait) || (state_q == StDrain);
    tick         = active && (!mode_q || i_dbg_step);
    front_freeze = 1'b0;
    if (tick) begin
      case (state_q)
        StRun:            front_freeze = i_halt_ID || (i_jr_stall && !jr_pass_q) || i_load_stall;
        StJrWait, StDrain: front_freeze = 1'b1;
        default:          front_freeze = 1'b0;
      endcase
    end
    o_pipe_en      = tick;
    o_pc_en        = tick && !front_freeze;
    o_if_id_en     = tick && !front_freeze;
    o_id_ex_bubble = front_freeze;
    o_halted       = (state_q == StHalted);
  end

  // The stall/drain counter holds the ticks remaining after the one that loaded it,
  // so the exit happens on the tick where it would decrement to zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= StIdle;
      mode_q    <= 1'b0;
      jr_pass_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i_dbg_step) begin
            state_q <= StRun;
            mode_q  <= 1'b1;
          end else if (i_dbg_run) begin
            state_q <= StRun;
            mode_q  <= 1'b0;
          end
        end
        StRun, StJrWait, StDrain: begin
          if (i_dbg_step) begin
            mode_q <= 1'b1;
          end else if (i_dbg_run) begin
            mode_q <= 1'b0;
          end
          if (tick) begin
            case (state_q)
              StRun: begin
                jr_pass_q <= 1'b0;
                if (i_halt_ID) begin
                  if (DRAIN_CYCLES <= 1) begin
                    state_q <= StHalted;
                  end else begin
                    cnt_q   <= DRAIN_LOAD;
                    state_q <= StDrain;
                  end
                end else if (i_jr_stall && !jr_pass_q) begin
                  if (JR_STALL_CYCLES <= 1) begin
                    jr_pass_q <= 1'b1;
                  end else begin
                    cnt_q   <= JR_LOAD;
                    state_q <= StJrWait;
                  end
                end
              end
              StJrWait: begin
                cnt_q <= cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                  state_q   <= StRun;
                  jr_pass_q <= 1'b1;
                end
              end
              StDrain: begin
                cnt_q <= cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                  state_q <= StHalted;
                end
              end
              default: begin
                state_q <= state_q;
              end
            endcase
          end
        end
        StHalted: begin
          state_q <= StHalted;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  tick_counter #(
    .WIDTH (CYC_W)
  ) u_tick_counter (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (tick),
    .o_count (o_cycle_cnt)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed scoreboard bench for pipeline_ctrl: stimulus queues expectations, monitor checks them.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_stall, jr_stall, halt_id, dbg_run, dbg_step;
  logic        pc_en, if_id_en, id_ex_bubble, pipe_en, halted;
  logic [31:0] cycle_cnt;

  // Expected enables packed as {pc_en, if_id_en, bubble, pipe_en, halted}.
  localparam logic [4:0] RUNV = 5'b11010;
  localparam logic [4:0] FRZ  = 5'b00110;
  localparam logic [4:0] OFF  = 5'b00000;
  localparam logic [4:0] HLT  = 5'b00001;

  typedef struct {
    int          id;
    logic [4:0]  en;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   n_step = 0;
  logic [31:0] ecnt = 0;

  always #5 clk = ~clk;

  pipeline_ctrl dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_load_stall   (load_stall),
    .i_jr_stall     (jr_stall),
    .i_halt_ID      (halt_id),
    .i_dbg_run      (dbg_run),
    .i_dbg_step     (dbg_step),
    .o_pc_en        (pc_en),
    .o_if_id_en     (if_id_en),
    .o_id_ex_bubble (id_ex_bubble),
    .o_pipe_en      (pipe_en),
    .o_halted       (halted),
    .o_cycle_cnt    (cycle_cnt)
  );

  // One clock cycle of stimulus plus the response expected in that same cycle.
  task automatic cyc(input logic rst, input logic ld, input logic jr, input logic hl,
                     input logic run, input logic st, input logic [4:0] e);
    exp_t x;
    @(posedge clk);
    #1;
    rst_n      = rst;
    load_stall = ld;
    jr_stall   = jr;
    halt_id    = hl;
    dbg_run    = run;
    dbg_step   = st;
    if (!rst) ecnt = 0;
    x.id  = n_step;
    x.en  = e;
    x.cnt = ecnt;
    exp_q.push_back(x);
    n_step++;
    if (e[1]) ecnt = ecnt + 1;
  endtask

  // Monitor: outputs are presented every cycle, checked mid-cycle away from the edge.
  initial begin
    exp_t e;
    logic [4:0] act;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = {pc_en, if_id_en, id_ex_bubble, pipe_en, halted};
        n_cmp++;
        if (act !== e.en || cycle_cnt !== e.cnt) begin
          n_fail++;
          $display("FAIL step%0d: got en=%b cnt=%0d, want en=%b cnt=%0d",
                   e.id, act, cycle_cnt, e.en, e.cnt);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    {load_stall, jr_stall, halt_id, dbg_run, dbg_step} = '0;

    // Reset and idle
    cyc(0, 0, 0, 0, 0, 0, OFF);
    cyc(1, 0, 0, 0, 0, 0, OFF);
    cyc(1, 0, 0, 0, 0, 0, OFF);

    // Continuous run: transition cycle is not a tick, then ten free-running ticks
    cyc(1, 0, 0, 0, 1, 0, OFF);
    for (int i = 0; i < 10; i++) cyc(1, 0, 0, 0, 0, 0, RUNV);

    // Single-cycle load-use stall
    cyc(1, 1, 0, 0, 0, 0, FRZ);
    cyc(1, 0, 0, 0, 0, 0, RUNV);

    // JR stall held: 3 bubbles, guaranteed advance, then re-stall
    for (int i = 0; i < 3; i++) cyc(1, 0, 1, 0, 0, 0, FRZ);
    cyc(1, 0, 1, 0, 0, 0, RUNV);
    for (int i = 0; i < 3; i++) cyc(1, 0, 1, 0, 0, 0, FRZ);
    cyc(1, 0, 1, 0, 0, 0, RUNV);
    cyc(1, 0, 0, 0, 0, 0, RUNV);

    // Step mode: the switching pulse is itself a tick, then only pulses tick
    cyc(1, 0, 0, 0, 0, 1, RUNV);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 0, 0, OFF);
    cyc(1, 0, 0, 0, 0, 1, RUNV);
    cyc(1, 1, 0, 0, 0, 0, OFF);
    // JR stall in step mode consumes three pulses, fourth pulse advances
    for (int p = 0; p < 3; p++) begin
      cyc(1, 0, 1, 0, 0, 1, FRZ);
      for (int i = 0; i < 4; i++) cyc(1, 0, 1, 0, 0, 0, OFF);
    end
    cyc(1, 0, 1, 0, 0, 1, RUNV);
    cyc(1, 0, 0, 0, 1, 0, OFF);
    cyc(1, 0, 0, 0, 0, 0, RUNV);

    // HALT with a simultaneous load stall: drain wins, then frozen for good
    cyc(1, 1, 0, 1, 0, 0, FRZ);
    cyc(1, 0, 0, 0, 0, 0, FRZ);
    cyc(1, 0, 0, 0, 0, 0, FRZ);
    cyc(1, 0, 0, 0, 0, 0, HLT);
    cyc(1, 1, 1, 1, 1, 1, HLT);
    cyc(1, 0, 0, 0, 0, 0, HLT);

    // Reset escapes HALTED; then reset again mid-drain with cnt=1
    cyc(0, 0, 0, 0, 0, 0, OFF);
    cyc(1, 0, 0, 0, 1, 0, OFF);
    cyc(1, 0, 0, 0, 0, 0, RUNV);
    cyc(1, 0, 0, 1, 0, 0, FRZ);
    cyc(1, 0, 0, 0, 0, 0, FRZ);
    cyc(0, 0, 0, 0, 0, 0, OFF);
    cyc(1, 0, 0, 0, 0, 0, OFF);
    cyc(1, 0, 0, 0, 1, 0, OFF);
    cyc(1, 0, 0, 0, 0, 0, RUNV);
    cyc(1, 0, 0, 0, 0, 0, RUNV);

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_queue: got %0d pending, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Pipeline sequencing controller for the 5-stage MIPS core. It converts the hazard unit's stall requests, the decoded HALT, and the debug unit's run/step commands into per-stage register enables and a bubble-insert strobe. It also counts executed cycles for the debug unit. It sits between the hazard unit, the debug unit and the pipeline latches (PC, IF/ID, ID/EX, EX/MA, MA/WB).

## Interface
- `JR_STALL_CYCLES`, default 3: bubbles inserted for a JR/JALR register dependency.
- `DRAIN_CYCLES`, default 3: ticks needed to retire EX, MA and WB after HALT.
- `CYC_W`, default 32: cycle counter width.
- `i_clk`  in  1: single clock, rising edge.
- `i_rst_n`  in  1: asynchronous, active-low reset.
- `i_load_stall`  in  1: load-use stall request (combinational, same cycle).
- `i_jr_stall`  in  1: JR/JALR in ID depends on an in-flight write (level).
- `i_halt_ID`  in  1: HALT decoded in ID.
- `i_dbg_run`  in  1: pulse; selects continuous mode.
- `i_dbg_step`  in  1: pulse; selects step mode and advances one tick.
- `o_pc_en`  out  1: PC write enable.
- `o_if_id_en`  out  1: IF/ID latch enable.
- `o_id_ex_bubble`  out  1: load NOP into ID/EX instead of the ID outputs.
- `o_pipe_en`  out  1: enable for ID/EX, EX/MA and MA/WB.
- `o_halted`  out  1: core fully drained.
- `o_cycle_cnt`  out  CYC_W: number of ticks executed.

## Operation
- States:
  - IDLE: after reset.
  - RUN
  - JR_WAIT
  - DRAIN
  - HALTED
- Register `r_mode`: 0 is continuous, 1 is step.
- tick = state ∈ {RUN, JR_WAIT, DRAIN} and (r_mode==0 or i_dbg_step).
- All outputs are Mealy (combinational from state and inputs). When there is no tick, all four enables are 0 and the bubble is 0: the pipeline is frozen.
- IDLE: all enables 0.
  - i_dbg_step: go to RUN with r_mode=1.
  - Otherwise i_dbg_run: go to RUN with r_mode=0.
  - If both arrive together, step wins.
  - The transition cycle itself is not a tick.
- In any non-IDLE, non-HALTED state:
  - i_dbg_run clears r_mode.
  - i_dbg_step sets r_mode.
- RUN on a tick, priority halt > jr > load:
  - i_halt_ID: front freeze (pc_en=0, if_id_en=0, bubble=1, pipe_en=1). Load cnt=DRAIN_CYCLES-1 and go to DRAIN.
  - i_jr_stall and r_jr_pass==0: front freeze. Load cnt=JR_STALL_CYCLES-1 and go to JR_WAIT.
  - i_load_stall: front freeze for this tick only; stay in RUN.
  - Otherwise: all enables 1, bubble 0.
- JR_WAIT on a tick:
  - Front freeze; cnt decrements.
  - At cnt==0, go to RUN and set r_jr_pass=1.
  - i_jr_stall, i_load_stall and i_halt_ID are ignored in this state.
- r_jr_pass: suppresses i_jr_stall for the next RUN tick so the JR advances. It clears on that tick.
- DRAIN on a tick:
  - pc_en=0, if_id_en=0, bubble=1, pipe_en=1; cnt decrements.
  - At cnt==0, go to HALTED.
- HALTED:
  - All enables 0, o_halted=1.
  - Exits only on reset.
  - Debug commands are ignored.
- o_cycle_cnt: increments on every tick and wraps at 2^CYC_W. It is not incremented in IDLE or HALTED.

## Timing
- Reset (asynchronous, on i_rst_n low):
  - State IDLE, r_mode=0, r_jr_pass=0, cnt=0, o_cycle_cnt=0.
  - All outputs 0.
- Reset asserted mid-stall or mid-drain aborts immediately to IDLE. No partial drain completes.
- Stall latency is zero cycles: a request seen in cycle N gates the enables in cycle N.
- Bubble counts:
  - Load stall: exactly 1 bubble per tick in which it is asserted.
  - JR stall: exactly JR_STALL_CYCLES consecutive bubble ticks, then one guaranteed advance tick.
- HALT: o_halted rises DRAIN_CYCLES ticks after the tick that saw i_halt_ID.
- Step mode: each i_dbg_step pulse is exactly one tick. Stall and drain counters advance only on ticks.

## Structure
- Package `pipeline_ctrl_pkg`: state enum (IDLE, RUN, JR_WAIT, DRAIN, HALTED) and the default constants JR_STALL_CYCLES=3, DRAIN_CYCLES=3, CYC_W=32.
- One sub-module, `tick_counter`: CYC_W-bit wrapping counter with enable and async active-low clear. It drives o_cycle_cnt.
- Counter width for cnt: $clog2 of the larger of JR_STALL_CYCLES and DRAIN_CYCLES, minimum 1.

## Test plan
- Reset, then i_dbg_run pulse, no requests: enables all 1 from cycle 2. After 10 cycles o_cycle_cnt=10.
- RUN with i_load_stall high for 1 cycle: that cycle pc_en=0, if_id_en=0, bubble=1, pipe_en=1. Next cycle all enables 1.
- i_jr_stall held high: 3 consecutive bubble cycles, then 1 cycle with all enables 1 despite i_jr_stall=1, then re-stall if it is still asserted.
- i_halt_ID and i_load_stall together in RUN: the drain path is taken. o_halted=1 after 3 cycles and all enables stay 0 afterwards. o_cycle_cnt stops.
- Step mode: i_dbg_step pulses spaced 5 cycles apart. Enables are active only in the pulse cycles, o_cycle_cnt increments by 1 per pulse, and a JR stall consumes 3 pulses.
- i_rst_n dropped during DRAIN (cnt=1): all outputs 0 immediately, state IDLE, o_cycle_cnt=0.
